// File: rtl/hwpe_stream_package.sv
// Shared types and sizing helpers for HWPE stream buffers.
package hwpe_stream_package;

    localparam int unsigned BUFFER_MAX_DEPTH = 256;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned buffer_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned buffer_ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int unsigned BUFFER_STATUS_LEVEL_W = buffer_cnt_width(BUFFER_MAX_DEPTH);

    // Sized for the largest legal buffer so controllers can aggregate several instances.
    typedef struct packed {
        logic [BUFFER_STATUS_LEVEL_W-1:0] level;
        logic                             full;
        logic                             empty;
    } buffer_status_t;

endpackage

// File: rtl/hwpe_stream_buffer_ptr.sv
// Modulo-DEPTH pointer with explicit wrap, usable for non power-of-two depths.
module hwpe_stream_buffer_ptr
    import hwpe_stream_package::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (clear_i) begin
            ptr_next = '0;
        end else if (inc_i) begin
            ptr_next = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr_o = ptr_reg;

endmodule

// File: rtl/hwpe_stream_buffer_elastic.sv
// DEPTH-entry elastic stream buffer: every output is derived from registered state,
// giving a full timing cut between the push and pop sides.
module hwpe_stream_buffer_elastic
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned STRB_W    = DATA_WIDTH / 8,
    localparam int unsigned CNT_W     = buffer_cnt_width(DEPTH),
    localparam int unsigned PTR_W     = buffer_ptr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic [STRB_W-1:0]     push_strb_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [STRB_W-1:0]     pop_strb_o,
    output logic [CNT_W-1:0]      level_o
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + STRB_W;

    logic [CNT_W-1:0]              cnt_reg;
    logic [CNT_W-1:0]              cnt_next;
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic                          push_hs;
    logic                          pop_hs;
    logic                          push_en;
    logic                          pop_en;
    logic [DEPTH-1:0][ENTRY_W-1:0] entries;
    logic [ENTRY_W-1:0]            rd_entry;

    assign push_ready_o = (cnt_reg != CNT_W'(DEPTH));
    assign pop_valid_o  = (cnt_reg != '0);
    assign push_hs      = push_valid_i & push_ready_o;
    assign pop_hs       = pop_valid_o & pop_ready_i;
    // Clear wins over both handshakes; a push in the clear cycle is dropped.
    assign push_en      = push_hs & ~clear_i;
    assign pop_en       = pop_hs & ~clear_i;

    hwpe_stream_buffer_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) i_wr_ptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .inc_i   (push_en),
        .ptr_o   (wr_ptr)
    );

    hwpe_stream_buffer_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) i_rd_ptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .inc_i   (pop_en),
        .ptr_o   (rd_ptr)
    );

    always_comb begin
        cnt_next = cnt_reg;
        if (clear_i) begin
            cnt_next = '0;
        end else begin
            case ({push_hs, pop_hs})
                2'b10:   cnt_next = cnt_reg + 1'b1;
                2'b01:   cnt_next = cnt_reg - 1'b1;
                default: cnt_next = cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    entry_reg <= '0;
                end else if (push_en && (wr_ptr == PTR_W'(gi))) begin
                    entry_reg <= {push_strb_i, push_data_i};
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rd_entry = entries[rd_ptr];

    // Stale storage is masked while empty so the output stays deterministic.
    assign pop_data_o = pop_valid_o ? rd_entry[DATA_WIDTH-1:0] : '0;
    assign pop_strb_o = pop_valid_o ? rd_entry[ENTRY_W-1:DATA_WIDTH] : '0;
    assign level_o    = cnt_reg;

    a_push_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (push_valid_i && !push_ready_o) |=>
        (push_valid_i && $stable(push_data_i) && $stable(push_strb_i)));

    a_pop_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (pop_valid_o && !pop_ready_i) |=>
        (pop_valid_o && $stable(pop_data_o) && $stable(pop_strb_o)));

endmodule

// File: tb/tb_hwpe_stream_buffer_elastic.sv
// Directed bench: a DEPTH=2 instance for streaming, a DEPTH=3 instance for corner cases.
module tb_hwpe_stream_buffer_elastic;

    logic        clk;
    logic        rst_n;
    logic        clear;

    logic        p2_valid, p2_ready, q2_valid, q2_ready;
    logic [31:0] p2_data, q2_data;
    logic [3:0]  p2_strb, q2_strb;
    logic [1:0]  lvl2;

    logic        p3_valid, p3_ready, q3_valid, q3_ready;
    logic [31:0] p3_data, q3_data;
    logic [3:0]  p3_strb, q3_strb;
    logic [1:0]  lvl3;

    int tests = 0;
    int fails = 0;

    hwpe_stream_buffer_elastic #(.DATA_WIDTH(32), .DEPTH(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0),
        .push_valid_i(p2_valid), .push_ready_o(p2_ready),
        .push_data_i(p2_data), .push_strb_i(p2_strb),
        .pop_valid_o(q2_valid), .pop_ready_i(q2_ready),
        .pop_data_o(q2_data), .pop_strb_o(q2_strb),
        .level_o(lvl2)
    );

    hwpe_stream_buffer_elastic #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .push_valid_i(p3_valid), .push_ready_o(p3_ready),
        .push_data_i(p3_data), .push_strb_i(p3_strb),
        .pop_valid_o(q3_valid), .pop_ready_i(q3_ready),
        .pop_data_o(q3_data), .pop_strb_o(q3_strb),
        .level_o(lvl3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pv;
        logic [31:0] d;
        logic [3:0]  s;
        logic        pr;
        logic        cl;
        logic        er;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  es;
        logic [1:0]  el;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic pv, input logic [31:0] d, input logic [3:0] s,
                                input logic pr, input logic cl, input logic er, input logic ev,
                                input logic [31:0] ed, input logic [3:0] es, input logic [1:0] el);
        vec_t v;
        v.pv = pv; v.d = d; v.s = s; v.pr = pr; v.cl = cl;
        v.er = er; v.ev = ev; v.ed = ed; v.es = es; v.el = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check3(input string tag, input logic er, input logic ev,
                          input logic [31:0] ed, input logic [3:0] es, input logic [1:0] el);
        check({tag, ".ready"}, {31'b0, p3_ready}, {31'b0, er});
        check({tag, ".valid"}, {31'b0, q3_valid}, {31'b0, ev});
        check({tag, ".data"},  q3_data, ed);
        check({tag, ".strb"},  {28'b0, q3_strb}, {28'b0, es});
        check({tag, ".level"}, {30'b0, lvl3}, {30'b0, el});
    endtask

    task automatic push3(input logic pv, input logic [31:0] d, input logic [3:0] s, input logic pr);
        @(negedge clk);
        p3_valid = pv; p3_data = d; p3_strb = s; q3_ready = pr;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        p2_valid = 1'b0; p2_data = '0; p2_strb = '0; q2_ready = 1'b0;
        p3_valid = 1'b0; p3_data = '0; p3_strb = '0; q3_ready = 1'b0;

        vecs[0]  = mk(1'b1, 32'hA,  4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  4'h0, 2'd0);
        vecs[1]  = mk(1'b1, 32'hB,  4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA,  4'hF, 2'd1);
        vecs[2]  = mk(1'b1, 32'hC,  4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA,  4'hF, 2'd2);
        vecs[3]  = mk(1'b1, 32'hD,  4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA,  4'hF, 2'd3);
        vecs[4]  = mk(1'b1, 32'hD,  4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB,  4'h3, 2'd2);
        vecs[5]  = mk(1'b0, 32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC,  4'hC, 2'd2);
        vecs[6]  = mk(1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD,  4'h5, 2'd1);
        vecs[7]  = mk(1'b1, 32'hE,  4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD,  4'h5, 2'd1);
        vecs[8]  = mk(1'b1, 32'h55, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 32'hD,  4'h5, 2'd2);
        vecs[9]  = mk(1'b0, 32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  4'h0, 2'd0);
        vecs[10] = mk(1'b1, 32'h66, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  4'h0, 2'd0);
        vecs[11] = mk(1'b0, 32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h66, 4'h9, 2'd1);
        vecs[12] = mk(1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  4'h0, 2'd0);

        // Reset and idle.
        #12;
        check3("reset", 1'b1, 1'b0, 32'h0, 4'h0, 2'd0);
        check("reset2.ready", {31'b0, p2_ready}, 32'd1);
        check("reset2.valid", {31'b0, q2_valid}, 32'd0);
        check("reset2.level", {30'b0, lvl2}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 check3("idle", 1'b1, 1'b0, 32'h0, 4'h0, 2'd0);
        $display("[TB] reset/idle checked");

        // Back-to-back streaming through the DEPTH=2 instance.
        for (int c = 0; c <= 256; c++) begin
            @(negedge clk);
            q2_ready = 1'b1;
            p2_valid = (c < 256);
            p2_data  = (c < 256) ? 32'(c + 1) : 32'h0;
            p2_strb  = 4'hF;
            #1;
            check($sformatf("stream%0d.ready", c), {31'b0, p2_ready}, 32'd1);
            check($sformatf("stream%0d.level_le1", c), {31'b0, (lvl2 <= 2'd1)}, 32'd1);
            if (c == 0) begin
                check("stream0.valid", {31'b0, q2_valid}, 32'd0);
            end else begin
                check($sformatf("stream%0d.valid", c), {31'b0, q2_valid}, 32'd1);
                check($sformatf("stream%0d.data", c), q2_data, 32'(c));
                check($sformatf("stream%0d.strb", c), {28'b0, q2_strb}, 32'hF);
                $display("[TB] stream word %0d out 0x%0h strb 0x%0h level %0d", c, q2_data, q2_strb, lvl2);
            end
        end
        @(negedge clk);
        p2_valid = 1'b0;
        #1 check("stream.drained", {31'b0, q2_valid}, 32'd0);
        check("stream.level0", {30'b0, lvl2}, 32'd0);

        // Fill/stall/wrap, full-pop-push and clear on the DEPTH=3 instance.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            p3_valid = vecs[i].pv; p3_data = vecs[i].d; p3_strb = vecs[i].s;
            q3_ready = vecs[i].pr; clear = vecs[i].cl;
            #1;
            check3($sformatf("v%0d", i), vecs[i].er, vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].el);
            check($sformatf("v%0d.no55", i), {31'b0, (q3_valid && q3_data == 32'h55)}, 32'd0);
            $display("[TB] vec %0d push=%0b 0x%0h pop_rdy=%0b clr=%0b -> rdy=%0b vld=%0b data=0x%0h lvl=%0d",
                     i, vecs[i].pv, vecs[i].d, vecs[i].pr, vecs[i].cl, p3_ready, q3_valid, q3_data, lvl3);
        end

        // Asynchronous reset while full, then traffic from empty.
        push3(1'b1, 32'h11, 4'h1, 1'b0);
        push3(1'b1, 32'h22, 4'h2, 1'b0);
        push3(1'b1, 32'h33, 4'h3, 1'b0);
        push3(1'b0, 32'h0,  4'h0, 1'b0);
        #1 check3("full", 1'b0, 1'b1, 32'h11, 4'h1, 2'd3);
        #1 rst_n = 1'b0;
        #1 check3("async_rst", 1'b1, 1'b0, 32'h0, 4'h0, 2'd0);
        $display("[TB] async reset asserted mid-cycle, level %0d", lvl3);
        @(negedge clk); #2 rst_n = 1'b1;
        push3(1'b1, 32'h44, 4'h6, 1'b1);
        #1 check3("post_rst0", 1'b1, 1'b0, 32'h0, 4'h0, 2'd0);
        push3(1'b0, 32'h0, 4'h0, 1'b1);
        #1 check3("post_rst1", 1'b1, 1'b1, 32'h44, 4'h6, 2'd1);
        push3(1'b0, 32'h0, 4'h0, 1'b0);
        #1 check3("post_rst2", 1'b1, 1'b0, 32'h0, 4'h0, 2'd0);
        $display("[TB] post-reset word 0x44 transferred");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
